sd_emmc_sync_fifo: RTL and testbench
====================================

Name: sd_emmc_sync_fifo

Overview:
- Parametrised single-clock data FIFO for SD/eMMC block transfers.
- Successor to the fixed 32x128 dual-FIFO buffer. Adds a valid/ready handshake, fill level, programmable watermarks, block-granular availability flags and flush.
- One instance per direction: AXI->card (write path) and card->AXI (read path).
- Sits between the AXI DMA engine and the SD data-line serialiser, both in the aclk domain.

Parameters:
- DATA_W, 32, data word width in bits (>=8).
- DEPTH, 128, storage entries; power of two, >=4.
- BLK_WORDS, 128, words per card block (512 B / 4); must be <=DEPTH.
- AW, $clog2(DEPTH), local, not overridable.

Ports:
- aclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  discard all contents, single-cycle pulse
- wr_valid_i  in  1  write request
- wr_data_i  in  DATA_W  write data
- wr_ready_o  out  1  space available
- rd_valid_o  out  1  read data valid
- rd_data_o  out  DATA_W  head word
- rd_ready_i  in  1  consumer accepts head word
- level_o  out  AW+1  words held, 0..DEPTH
- af_thr_i  in  AW+1  almost-full threshold
- ae_thr_i  in  AW+1  almost-empty threshold
- almost_full_o  out  1  level_o >= af_thr_i
- almost_empty_o  out  1  level_o <= ae_thr_i
- blk_avail_o  out  1  level_o >= BLK_WORDS; a full block can be drained
- blk_space_o  out  1  DEPTH-level_o >= BLK_WORDS; a full block can be accepted

Behaviour:
- Clock and reset: one clock, aclk. Reset rst is synchronous and active-high.
- Reset values:
  - Pointers and level cleared.
  - wr_ready_o=1, rd_valid_o=0, level_o=0.
  - almost_empty_o=1 when ae_thr_i>=0 (always true at level 0); almost_full_o = (af_thr_i==0).
  - blk_avail_o=0, blk_space_o=1.
  - rd_data_o don't-care.
  - Storage array not reset.
- Handshakes:
  - Write occurs when wr_valid_i & wr_ready_o. Read occurs when rd_valid_o & rd_ready_i.
  - wr_ready_o = (level_o != DEPTH). Never depends combinationally on wr_valid_i.
  - rd_valid_o = (level_o != 0).
- Read path: first-word-fall-through. rd_data_o shows the head entry combinationally from the pointer; 0-cycle read latency.
- Write-to-read latency: a word written in cycle N is visible on rd_data_o, with rd_valid_o=1, in cycle N+1.
- Pointers:
  - AW-bit wr_ptr and rd_ptr wrap naturally at DEPTH.
  - Full/empty are derived from level_o, not from pointer compare.
- Level update each cycle: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous write and read:
  - When full: legal. The read frees the slot, but wr_ready_o is already 0, so no write occurs that cycle.
  - When empty: no read occurs, since rd_valid_o=0. The write lands, and the word appears next cycle.
- Flush: flush_i=1 clears pointers and level next cycle and ignores any write or read in the same cycle. Priority is rst > flush_i > write/read.
- Reset or flush mid-block: partial block discarded; no residual blk_avail_o.
- Status outputs: all combinational from the registered level_o and the threshold inputs.
- Thresholds: may change at any time and take effect the same cycle. af_thr_i > DEPTH means almost_full_o is never set.
- Illegal parameter combinations (non-power-of-2 DEPTH, BLK_WORDS>DEPTH) are rejected by an elaboration-time $error.

Optional Feature:
- Macro SD_FIFO_OUTREG_EN.
- Defined: rd_data_o and rd_valid_o come from an output register fed by the RAM.
  - Write-to-read latency becomes 2 cycles.
  - The output register counts in level_o. Total capacity stays DEPTH, and full still means level_o==DEPTH.
  - Back-to-back reads sustain 1 word/cycle.
  - flush_i and rst also clear the output register valid bit.
- Undefined: pure FWFT as above, with no output register.

Decomposition:
- Package sd_emmc_pkg:
  - SD_BLK_BYTES=512.
  - Default DATA_W and DEPTH constants.
  - Helper function computing BLK_WORDS from DATA_W.
- Sub-module: sd_emmc_fifo_ram, a simple dual-port flop array with one write port and one async read port. It is swappable for an SRAM macro.
- All control logic stays in the top module.

Test Plan:
- Reset, then write 128 words 0..127 with rd_ready_i=0:
  - wr_ready_o drops after the 128th write; level_o=128.
  - blk_avail_o=1, blk_space_o=0.
  - A 129th write is not accepted.
- Full FIFO, then hold wr_valid_i=1 and rd_ready_i=1 for 200 cycles:
  - Read data is exactly 0,1,2,... in order with no gaps or duplicates.
  - Pointers wrap past 127 correctly.
- Empty FIFO, then single write 0xA5A5A5A5 at cycle N:
  - rd_valid_o=1 with that data at N+1 (N+2 with SD_FIFO_OUTREG_EN).
  - level_o returns to 0 after the read.
- af_thr_i=100, ae_thr_i=4; fill from 0 to 128:
  - almost_empty_o deasserts at level 5.
  - almost_full_o asserts at level 100.
  - blk_space_o deasserts at level 1.
- Write 60 words, pulse flush_i together with a write and a read:
  - Next cycle level_o=0 and rd_valid_o=0.
  - The same-cycle write is not stored.
- Assert rst at level 77 during concurrent traffic:
  - Next cycle all outputs hold their reset values.
  - Subsequent data contains no pre-reset words.

Source files
------------

// File: rtl/sd_emmc_pkg.sv
// sd_emmc_pkg: shared constants for the SD/eMMC data FIFO.
//   SD_BLK_BYTES   - bytes per card data block
//   SD_DEF_DATA_W  - default FIFO word width
//   SD_DEF_DEPTH   - default FIFO depth
//   sd_blk_words() - words per card block for a given word width
package sd_emmc_pkg;

    localparam int SD_BLK_BYTES  = 512;
    localparam int SD_DEF_DATA_W = 32;
    localparam int SD_DEF_DEPTH  = 128;

    function automatic int sd_blk_words(input int data_w);
        return (SD_BLK_BYTES * 8) / data_w;
    endfunction

endpackage

// File: rtl/sd_emmc_fifo_ram.sv
// sd_emmc_fifo_ram: simple dual-port storage, one synchronous write port and
// one asynchronous read port. Kept separate so it can be swapped for an SRAM
// macro. Contents are not reset.
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module sd_emmc_fifo_ram
    import sd_emmc_pkg::*;
#(
    parameter int   DATA_W = SD_DEF_DATA_W,
    parameter int   DEPTH  = SD_DEF_DEPTH,
    localparam int  AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sd_emmc_sync_fifo.sv
// sd_emmc_sync_fifo: single-clock data FIFO between the AXI DMA engine and
// the SD data-line serialiser. Valid/ready on both sides, fill level,
// programmable almost-full/almost-empty, block-granular availability flags
// and a single-cycle flush.
//
// Build option: define SD_FIFO_OUTREG_EN to drive rd_data_o/rd_valid_o from
// an output register (2-cycle write-to-read latency). Undefined: pure
// first-word-fall-through.
//
// Ports:
//   aclk, rst         - clock, synchronous active-high reset
//   flush_i           - discard all contents (pulse)
//   wr_valid_i/wr_data_i/wr_ready_o - write handshake
//   rd_valid_o/rd_data_o/rd_ready_i - read handshake (head word)
//   level_o           - words held, 0..DEPTH
//   af_thr_i/ae_thr_i - almost-full / almost-empty thresholds
//   almost_full_o, almost_empty_o, blk_avail_o, blk_space_o - status
module sd_emmc_sync_fifo
    import sd_emmc_pkg::*;
#(
    parameter int   DATA_W    = SD_DEF_DATA_W,
    parameter int   DEPTH     = SD_DEF_DEPTH,
    parameter int   BLK_WORDS = sd_blk_words(DATA_W),
    localparam int  AW        = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_ready_i,
    output logic [AW:0]       level_o,
    input  logic [AW:0]       af_thr_i,
    input  logic [AW:0]       ae_thr_i,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              blk_avail_o,
    output logic              blk_space_o
);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sd_emmc_sync_fifo: DEPTH must be a power of two >= 4");
    end
    if (BLK_WORDS > DEPTH) begin : g_bad_blk
        $error("sd_emmc_sync_fifo: BLK_WORDS must not exceed DEPTH");
    end
    if (DATA_W < 8) begin : g_bad_width
        $error("sd_emmc_sync_fifo: DATA_W must be >= 8");
    end

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] BLK_LVL  = (AW+1)'(BLK_WORDS);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              wr_fire, rd_fire, rd_adv;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_ready_o = (level_q != FULL_LVL);
    assign wr_fire    = wr_valid_i & wr_ready_o;
    assign rd_fire    = rd_valid_o & rd_ready_i;

`ifdef SD_FIFO_OUTREG_EN
    // The output register holds the head word and counts in level_q, so the
    // RAM holds level_q - ov_q words. It refills whenever it is empty or being
    // drained, which keeps back-to-back reads at one word per cycle.
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [AW:0]       ram_cnt;
    logic              load;

    assign ram_cnt    = level_q - {{AW{1'b0}}, ov_q};
    assign load       = (ram_cnt != '0) && (!ov_q || rd_fire);
    assign rd_adv     = load;
    assign rd_valid_o = ov_q;
    assign rd_data_o  = dout_q;

    always_comb begin
        ov_d   = ov_q;
        dout_d = dout_q;
        if (flush_i) begin
            ov_d = 1'b0;
        end else if (load) begin
            ov_d   = 1'b1;
            dout_d = ram_rdata;
        end else if (rd_fire) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) ov_q <= 1'b0;
        else     ov_q <= ov_d;
        dout_q <= dout_d;
    end
`else
    assign rd_adv     = rd_fire;
    assign rd_valid_o = (level_q != '0);
    assign rd_data_o  = ram_rdata;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_adv)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    sd_emmc_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (aclk),
        .we    (wr_fire & ~flush_i),
        .waddr (wr_ptr_q),
        .wdata (wr_data_i),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign level_o        = level_q;
    assign almost_full_o  = (level_q >= af_thr_i);
    assign almost_empty_o = (level_q <= ae_thr_i);
    assign blk_avail_o    = (level_q >= BLK_LVL);
    assign blk_space_o    = ((FULL_LVL - level_q) >= BLK_LVL);

endmodule

// File: tb/tb_sd_emmc_sync_fifo.sv
// Bench for sd_emmc_sync_fifo (default parameters: 32-bit, 128 deep,
// 128-word blocks). A queue model predicts level, handshakes, head data and
// status flags; directed sequences add literal expectations.
module tb_sd_emmc_sync_fifo;

    localparam int DEPTH = 128;
    localparam int BLK   = 128;
`ifdef SD_FIFO_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [31:0] wr_data_i = '0;
    logic        wr_ready_o;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic        rd_ready_i = 1'b0;
    logic [7:0]  level_o;
    logic [7:0]  af_thr_i = 8'd0;
    logic [7:0]  ae_thr_i = 8'd0;
    logic        almost_full_o, almost_empty_o, blk_avail_o, blk_space_o;

    sd_emmc_sync_fifo dut (
        .aclk           (aclk),
        .rst            (rst),
        .flush_i        (flush_i),
        .wr_valid_i     (wr_valid_i),
        .wr_data_i      (wr_data_i),
        .wr_ready_o     (wr_ready_o),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .rd_ready_i     (rd_ready_i),
        .level_o        (level_o),
        .af_thr_i       (af_thr_i),
        .ae_thr_i       (ae_thr_i),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .blk_avail_o    (blk_avail_o),
        .blk_space_o    (blk_space_o)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of words plus the cycle each was written. A word may be
    // presented once it is LAT cycles old.
    logic [31:0] mq[$];
    int          mt[$];
    int          cyc = 0;
    bit          chk_en = 1'b0;

    function automatic bit m_rvalid();
        return (mq.size() != 0) && ((cyc - mt[0]) >= LAT);
    endfunction

    always @(posedge aclk) begin
        bit w, r;
        w = wr_valid_i && (mq.size() != DEPTH);
        r = rd_ready_i && m_rvalid();
        if (rst || flush_i) begin
            mq.delete();
            mt.delete();
        end else begin
            if (r) begin
                void'(mq.pop_front());
                void'(mt.pop_front());
            end
            if (w) begin
                mq.push_back(wr_data_i);
                mt.push_back(cyc);
            end
        end
        cyc++;
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            int l;
            l = mq.size();
            chk("m_level", level_o, l);
            chk("m_wr_ready", wr_ready_o, l != DEPTH);
            chk("m_rd_valid", rd_valid_o, m_rvalid());
            if (m_rvalid()) chk("m_rd_data", rd_data_o, mq[0]);
            chk("m_almost_full", almost_full_o, l >= int'(af_thr_i));
            chk("m_almost_empty", almost_empty_o, l <= int'(ae_thr_i));
            chk("m_blk_avail", blk_avail_o, l >= BLK);
            chk("m_blk_space", blk_space_o, (DEPTH - l) >= BLK);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int next_wr, exp_rd, k;
        // Reset with af_thr=0 so almost_full must read 1 at level 0
        step(); step();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_level", level_o, 0);
        chk("rst_wr_ready", wr_ready_o, 1);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_almost_empty", almost_empty_o, 1);
        chk("rst_almost_full", almost_full_o, 1);
        chk("rst_blk_avail", blk_avail_o, 0);
        chk("rst_blk_space", blk_space_o, 1);
        af_thr_i = 8'd200;

        // Fill with 0..127, nothing read
        wr_valid_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data_i = i;
            chk("fill_wr_ready", wr_ready_o, 1);
            step();
        end
        chk("full_level", level_o, 128);
        chk("full_wr_ready", wr_ready_o, 0);
        chk("full_blk_avail", blk_avail_o, 1);
        chk("full_blk_space", blk_space_o, 0);
        wr_data_i = 32'd999;
        step();
        chk("over_write_level", level_o, 128);
        next_wr = 128;
        exp_rd  = 0;

        // Streaming from full: data must be 0,1,2,... with wrap
        rd_ready_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wr_data_i = next_wr;
            if (rd_valid_o) begin
                chk("stream_data", rd_data_o, exp_rd);
                exp_rd++;
            end
            if (wr_ready_o) next_wr++;
            step();
        end
        wr_valid_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (level_o == 0) break;
            if (rd_valid_o) begin
                chk("drain_data", rd_data_o, exp_rd);
                exp_rd++;
            end
            step();
        end
        chk("drain_count", exp_rd, next_wr);
        chk("drain_level", level_o, 0);
        rd_ready_i = 1'b0;

        // Single-word latency
        wr_data_i  = 32'hA5A5A5A5;
        wr_valid_i = 1'b1;
        step();
        wr_valid_i = 1'b0;
`ifdef SD_FIFO_OUTREG_EN
        chk("lat_early_valid", rd_valid_o, 0);
        step();
`endif
        chk("lat_valid", rd_valid_o, 1);
        chk("lat_data", rd_data_o, 32'hA5A5A5A5);
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
        chk("lat_level_after", level_o, 0);
        chk("lat_valid_after", rd_valid_o, 0);

        // Threshold sweep 0..128
        af_thr_i = 8'd100;
        ae_thr_i = 8'd4;
        for (int l = 0; l <= DEPTH; l++) begin
            chk("sweep_level", level_o, l);
            chk("sweep_ae", almost_empty_o, l <= 4);
            chk("sweep_af", almost_full_o, l >= 100);
            chk("sweep_blk_space", blk_space_o, l == 0);
            wr_valid_i = (l < DEPTH);
            wr_data_i  = 32'h100 + l;
            step();
        end
        wr_valid_i = 1'b0;

        // Flush from full, then flush at 60 with same-cycle write and read
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_full_level", level_o, 0);
        wr_valid_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wr_data_i = 32'h200 + i;
            step();
        end
        chk("pre_flush_level", level_o, 60);
        flush_i    = 1'b1;
        rd_ready_i = 1'b1;
        wr_data_i  = 32'hDEAD;
        step();
        flush_i = 1'b0; wr_valid_i = 1'b0; rd_ready_i = 1'b0;
        chk("flush_level", level_o, 0);
        chk("flush_rd_valid", rd_valid_o, 0);
        step();
        chk("flush_nowrite_level", level_o, 0);
        chk("flush_nowrite_valid", rd_valid_o, 0);

        // Reset at level 77 with concurrent traffic
        wr_valid_i = 1'b1;
        for (int i = 0; i < 77; i++) begin
            wr_data_i = 32'h1000 + i;
            step();
        end
        chk("pre_rst_level", level_o, 77);
        rd_ready_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0; wr_valid_i = 1'b0; rd_ready_i = 1'b0;
        chk("mid_rst_level", level_o, 0);
        chk("mid_rst_wr_ready", wr_ready_o, 1);
        chk("mid_rst_rd_valid", rd_valid_o, 0);
        chk("mid_rst_blk_avail", blk_avail_o, 0);
        chk("mid_rst_blk_space", blk_space_o, 1);
        chk("mid_rst_ae", almost_empty_o, 1);
        chk("mid_rst_af", almost_full_o, 0);
        wr_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data_i = 32'h5000 + i;
            step();
        end
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (k == 3) break;
            if (rd_valid_o) begin
                chk("post_rst_data", rd_data_o, 32'h5000 + k);
                k++;
            end
            step();
        end
        rd_ready_i = 1'b0;
        chk("post_rst_count", k, 3);
        chk("post_rst_level", level_o, 0);

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
